// File: rtl/dla_reset_seq_pkg.sv
// Shared types and helpers for the per-domain reset release sequencer.
package dla_reset_seq_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_RELEASE,
    S_RUN,
    S_SOFT_HOLD
  } reset_seq_state_t;

  // Legal parameter set: at least one stage, non-zero gaps, two-flop minimum synchronizer.
  function automatic bit seq_params_ok(input int num_stages, input int gap, input int sync_depth,
                                       input int hold, input int cnt_width);
    return (num_stages >= 1) && (gap >= 1) && (sync_depth >= 2) && (hold >= 1) && (cnt_width >= 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dla_reset_release_sync.sv
// Async-assert / sync-deassert reset synchronizer: o_sync rises SYNC_DEPTH edges after rst drops.
module dla_reset_release_sync #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  // Shift a constant 1 in from the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], 1'b1};
  end

  // Chain flops clear immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign o_sync = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/dla_reset_release_sequencer.sv
// Per-domain reset sequencer: synchronizes platform reset release, releases stage resets
// in order with a fixed gap, reports done, and services a req/ack soft reset.
module dla_reset_release_sequencer
  import dla_reset_seq_pkg::*;
#(
  parameter int NUM_STAGES       = 4,
  parameter int STAGE_GAP_CYCLES = 16,
  parameter int SYNC_DEPTH       = 3,
  parameter int SOFT_HOLD_CYCLES = 32,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_soft_reset_req,
  output logic                  o_soft_reset_ack,
  output logic [NUM_STAGES-1:0] o_resetn_stage,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_soft_reset_count
);

  localparam int GW = $clog2(max2(STAGE_GAP_CYCLES, SOFT_HOLD_CYCLES) + 1);
  localparam int IW = $clog2(NUM_STAGES + 1);

  if (!seq_params_ok(NUM_STAGES, STAGE_GAP_CYCLES, SYNC_DEPTH, SOFT_HOLD_CYCLES, CNT_WIDTH)) begin : g_bad_params
    $error("dla_reset_release_sequencer: illegal parameter set");
  end

  logic sync_out;

  dla_reset_release_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk    (clk),
    .rst    (i_reset),
    .o_sync (sync_out)
  );

  reset_seq_state_t      state_q, state_d;
  logic [GW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  step;

  // Next-state logic. The cycle in which the synchronizer output is first seen already
  // counts as the first gap cycle, so stage 0 lands SYNC_DEPTH+GAP edges after release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    count_d = count_q;
    cnt_inc = cnt_q + 1'b1;
    step    = 1'b0;

    case (state_q)
      S_SYNC:      step = sync_out;
      S_RELEASE:   step = 1'b1;
      S_RUN: begin
        if (i_soft_reset_req) begin
          ack_d   = 1'b1;
          stage_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SOFT_HOLD;
          if (!(&count_q)) count_d = count_q + 1'b1;
        end
      end
      S_SOFT_HOLD: begin
        if (cnt_inc == GW'(SOFT_HOLD_CYCLES)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default:     state_d = S_SYNC;
    endcase

    // One release-gap tick: release the next stage, or finish after the trailing gap.
    if (step) begin
      state_d = S_RELEASE;
      if (cnt_inc == GW'(STAGE_GAP_CYCLES)) begin
        cnt_d = '0;
        if (idx_q == IW'(NUM_STAGES)) begin
          done_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IW'(k)) stage_d[k] = 1'b1;
          end
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // All sequencer state; i_reset clears everything asynchronously.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  assign o_resetn_stage     = stage_q;
  assign o_done             = done_q;
  assign o_soft_reset_ack   = ack_q;
  assign o_soft_reset_count = count_q;

endmodule
